// File: rtl/sram_pkg.sv
// Shared SRAM types and defaults used by the access controller and row decoder.
package sram_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 6;
  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_PRE_CYCLES = 1;
  localparam int unsigned DEF_WL_CYCLES  = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRECHARGE = 2'd1,
    ST_WORDLINE  = 2'd2,
    ST_RESPOND   = 2'd3
  } sram_state_e;

  // Larger of two phase lengths, used to size the phase timer.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// Loadable down-counter that measures the length of one array phase.
module sram_phase_timer #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             zero_c
);

  // Load wins over counting; the counter parks at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  // Last cycle of the current phase.
  assign zero_c = (count == '0);

endmodule

// File: rtl/sram_access_ctrl.sv
// Sequences one SRAM access per request: precharge, wordline, respond.
module sram_access_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned PRE_CYCLES = DEF_PRE_CYCLES,
  parameter int unsigned WL_CYCLES  = DEF_WL_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] dec_addr,
  output logic                  dec_enable,
  output logic                  bl_precharge,
  output logic                  wr_drive,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  sa_enable,
  input  logic [DATA_WIDTH-1:0] sa_data
);

  localparam int unsigned TMR_W = $clog2(max_u(PRE_CYCLES, WL_CYCLES) + 1);

  // Phase lengths of zero would collapse the FSM timing.
  if (PRE_CYCLES < 1 || WL_CYCLES < 1) begin : g_bad_cycles
    $error("sram_access_ctrl: PRE_CYCLES and WL_CYCLES must be >= 1");
  end

  sram_state_e      state, state_nx;
  logic             we_q;
  logic             accept;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic [TMR_W-1:0] tmr_count;
  logic             tmr_zero;
  logic             pre_nx, dec_nx, wr_nx, sa_nx, last_wl_nx;

  sram_phase_timer #(
    .WIDTH(TMR_W)
  ) u_phase_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .count    (tmr_count),
    .zero_c   (tmr_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state, timer control and next-cycle strobe decode.
  always_comb begin
    state_nx   = state;
    accept     = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    unique case (state)
      ST_IDLE: begin
        if (req_valid) begin
          accept   = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(PRE_CYCLES - 1);
          state_nx = ST_PRECHARGE;
        end
      end
      ST_PRECHARGE: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(WL_CYCLES - 1);
          state_nx = ST_WORDLINE;
        end
      end
      ST_WORDLINE: begin
        if (tmr_zero) begin
          state_nx = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        if (rsp_ready) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    // Next cycle is the final wordline cycle when the timer will read zero.
    last_wl_nx = tmr_load ? (tmr_val == '0) : (tmr_count == TMR_W'(1));
    pre_nx     = (state_nx == ST_PRECHARGE);
    dec_nx     = (state_nx == ST_WORDLINE);
    wr_nx      = dec_nx && we_q;
    sa_nx      = dec_nx && !we_q && last_wl_nx;
  end

  // Registered handshake and array strobes; async reset drops every strobe at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      bl_precharge <= 1'b0;
      dec_enable   <= 1'b0;
      wr_drive     <= 1'b0;
      sa_enable    <= 1'b0;
    end else begin
      req_ready    <= (state_nx == ST_IDLE);
      rsp_valid    <= (state_nx == ST_RESPOND);
      bl_precharge <= pre_nx;
      dec_enable   <= dec_nx;
      wr_drive     <= wr_nx;
      sa_enable    <= sa_nx;
    end
  end

  // Request latch and read-data capture at the edge leaving the wordline phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_addr  <= '0;
      wr_data   <= '0;
      we_q      <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      if (accept) begin
        dec_addr <= req_addr;
        wr_data  <= req_wdata;
        we_q     <= req_we;
      end
      if (state == ST_WORDLINE && tmr_zero && !we_q) begin
        rsp_rdata <= sa_data;
      end
    end
  end

endmodule
